mac_stream: RTL and testbench

Parametrised, pipelined, streaming signed multiply-accumulate unit, the next generation of the datapath's scalar MAC. It accepts (a, b) operand pairs over a valid/ready handshake, accumulates their products over a vector delimited by `in_last`, and presents the dot-product result over a second valid/ready handshake. It also reports beat count and overflow, and optionally saturates. It sits between the operand-fetch logic and the result writeback logic in the filter/neuron datapath.

---
 rtl/mac_pkg.sv | 17 +
 rtl/mac_sat_add.sv | 34 +++
 rtl/mac_stream.sv | 137 +++++++++++++
 tb/tb_mac_stream.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared constants and types for the streaming MAC datapath.
// Holds the default operand, accumulator and counter widths.
// Also holds the overflow-mode enum that the SAT parameter selects.
package mac_pkg;

    localparam int MAC_A_W   = 8;
    localparam int MAC_B_W   = 8;
    localparam int MAC_ACC_W = 26;
    localparam int MAC_CNT_W = 16;

    // Overflow handling of one accumulate step.
    typedef enum logic {
        MAC_WRAP = 1'b0,   // two's-complement wrap
        MAC_SAT  = 1'b1    // clamp to the signed min/max of the accumulator
    } mac_ovf_mode_e;

endpackage

// File: rtl/mac_sat_add.sv
// mac_sat_add: ACC_W-bit signed adder for one accumulate step.
// Ports:
//   acc    - current accumulator value (signed, ACC_W)
//   addend - sign-extended product (signed, ACC_W)
//   sum    - next accumulator value, wrapped or clamped according to MODE
//   ovf    - the true sum does not fit in ACC_W signed bits
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int            ACC_W = MAC_ACC_W,
    parameter mac_ovf_mode_e MODE  = MAC_WRAP
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] addend,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    // One guard bit holds the exact sum of two ACC_W-bit signed values.
    logic [ACC_W:0] wide;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        wide = {acc[ACC_W-1], acc} + {addend[ACC_W-1], addend};
        ovf  = wide[ACC_W] ^ wide[ACC_W-1];
        sum  = wide[ACC_W-1:0];
        if (MODE == MAC_SAT && ovf) begin
            // The guard bit carries the true sign of the sum.
            sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                              : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/mac_stream.sv
// mac_stream: two-stage pipelined streaming signed multiply-accumulate.
// Operand beats (a, b, in_last) arrive over in_vld/in_rdy.
// Each vector delimited by in_last produces one dot-product result on
// out_vld/out_rdy, together with the beat count and a sticky overflow flag.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   clr_n            - synchronous active-low flush of the in-flight vector
//   in_vld, in_rdy   - operand handshake
//   a, b, in_last    - signed operands, end-of-vector marker
//   out_vld, out_rdy - result handshake
//   out_acc          - signed dot product (ACC_W)
//   out_cnt          - beats in the vector, saturating (CNT_W)
//   out_ovf          - some accumulate step of the vector overflowed
module mac_stream
    import mac_pkg::*;
#(
    parameter int A_W   = MAC_A_W,
    parameter int B_W   = MAC_B_W,
    parameter int ACC_W = MAC_ACC_W,
    parameter int CNT_W = MAC_CNT_W,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic             in_last,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    localparam int            P_W  = A_W + B_W;
    localparam mac_ovf_mode_e MODE = (SAT != 0) ? MAC_SAT : MAC_WRAP;

    // S1: registered product
    logic signed [P_W-1:0] p;
    logic                  v1;
    logic                  last1;

    // S2: running state of the current vector
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] b_ext;
    logic [ACC_W-1:0]      p_ext;
    logic [ACC_W-1:0]      acc_sum;
    logic                  step_ovf;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  stall;
    logic                  step;
    logic                  load;

    // A result that cannot leave freezes both stages.
    assign stall  = out_vld && !out_rdy;
    assign in_rdy = clr_n && !stall;

    // Widen before multiplying so the full A_W+B_W product is kept.
    assign a_ext = P_W'($signed(a));
    assign b_ext = P_W'($signed(b));
    assign p_ext = ACC_W'(p);

    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
    assign step    = clr_n && v1 && !stall;
    assign load    = step && last1;

    mac_sat_add #(
        .ACC_W (ACC_W),
        .MODE  (MODE)
    ) u_add (
        .acc    (acc),
        .addend (p_ext),
        .sum    (acc_sum),
        .ovf    (step_ovf)
    );

    // S1 register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state is written with non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            v1    <= 1'b0;
            p     <= '0;
            last1 <= 1'b0;
        end else if (!clr_n) begin
            v1    <= 1'b0;
        end else if (!stall) begin
            // in_rdy is 1 here, so in_vld alone marks an accepted beat.
            v1    <= in_vld;
            p     <= a_ext * b_ext;
            last1 <= in_last;
        end
    end

    // S2 running accumulator; a finished vector restarts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (!clr_n || load) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (step) begin
            acc <= acc_sum;
            cnt <= cnt_inc;
            ovf <= ovf | step_ovf;
        end
    end

    // Result register; a flush leaves a pending result untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_acc <= '0;
            out_cnt <= '0;
            out_ovf <= 1'b0;
        end else if (load) begin
            // Loading is only possible when the previous result is gone or
            // leaving this very cycle, so nothing is overwritten.
            out_vld <= 1'b1;
            out_acc <= acc_sum;
            out_cnt <= cnt_inc;
            out_ovf <= ovf | step_ovf;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_stream.sv
// tb_mac_stream: self-checking bench for mac_stream.
// Three instances share the stimulus: default widths (wrap), ACC_W=16 with
// saturation, and ACC_W=16 with wrap. A vector-level model recomputes
// every result from the accepted operand beats with plain integer arithmetic.
// That model is compared with each instance on every cycle a result is
// presented. Directed scenarios pin literal values.
module tb_mac_stream;
    import mac_pkg::*;

    typedef struct {
        longint acc;
        longint cnt;
        longint ovf;
        int     cyc;      // cycle of delivery (or of last-beat acceptance)
        int     src_cyc;  // cycle the last beat was accepted
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr_n = 1'b1;
    logic       in_vld = 1'b0;
    logic       in_last = 1'b0;
    logic       out_rdy = 1'b1;
    logic [7:0] a = '0;
    logic [7:0] b = '0;

    logic        m_in_rdy, m_out_vld, m_out_ovf;
    logic [25:0] m_out_acc;
    logic [15:0] m_out_cnt;
    logic        s_in_rdy, s_out_vld, s_out_ovf;
    logic [15:0] s_out_acc;
    logic [15:0] s_out_cnt;
    logic        w_in_rdy, w_out_vld, w_out_ovf;
    logic [15:0] w_out_acc;
    logic [15:0] w_out_cnt;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   saw_bp_block = 0;
    longint cur[$];
    res_t exp_m[$], exp_s[$], exp_w[$];
    res_t got_m[$], got_s[$], got_w[$];

    always #5 clk = ~clk;

    mac_stream u_dut (
        .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .in_vld(in_vld), .in_rdy(m_in_rdy),
        .a(a), .b(b), .in_last(in_last), .out_vld(m_out_vld), .out_rdy(out_rdy),
        .out_acc(m_out_acc), .out_cnt(m_out_cnt), .out_ovf(m_out_ovf)
    );

    mac_stream #(.ACC_W(16), .SAT(1)) u_sat16 (
        .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .in_vld(in_vld), .in_rdy(s_in_rdy),
        .a(a), .b(b), .in_last(in_last), .out_vld(s_out_vld), .out_rdy(out_rdy),
        .out_acc(s_out_acc), .out_cnt(s_out_cnt), .out_ovf(s_out_ovf)
    );

    mac_stream #(.ACC_W(16), .SAT(0)) u_wrap16 (
        .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .in_vld(in_vld), .in_rdy(w_in_rdy),
        .a(a), .b(b), .in_last(in_last), .out_vld(w_out_vld), .out_rdy(out_rdy),
        .out_acc(w_out_acc), .out_cnt(w_out_cnt), .out_ovf(w_out_ovf)
    );

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Dot product of a whole vector in an accumulator of width w.
    function automatic res_t model_vec(input longint prods[$], input int w, input bit sat);
        longint one = 1;
        longint mx  = (one << (w - 1)) - 1;
        longint mn  = -(one << (w - 1));
        longint acc = 0;
        longint s;
        res_t   r;
        r.ovf = 0;
        foreach (prods[i]) begin
            s = acc + prods[i];
            if (s > mx || s < mn) begin
                r.ovf = 1;
                if (sat) s = (s > mx) ? mx : mn;
                else begin
                    s = s & ((one << w) - 1);
                    if (s > mx) s = s - (one << w);
                end
            end
            acc = s;
        end
        r.acc     = acc;
        r.cnt     = (prods.size() > 65535) ? 65535 : prods.size();
        r.cyc     = 0;
        r.src_cyc = 0;
        return r;
    endfunction

    // Model update and output comparison, sampled mid-cycle.
    always @(negedge clk) begin
        res_t r;
        cyc++;
        if (!rst_n) begin
            cur.delete();
            exp_m.delete();
            exp_s.delete();
            exp_w.delete();
        end else begin
            check("in_rdy", longint'(m_in_rdy), longint'(clr_n && !(m_out_vld && !out_rdy)));
            if (m_out_vld && !out_rdy && !m_in_rdy) saw_bp_block = 1;

            if (m_out_vld) begin
                check("main result pending", longint'(exp_m.size() > 0), 1);
                if (exp_m.size() > 0) begin
                    check("main out_acc", longint'($signed(m_out_acc)), exp_m[0].acc);
                    check("main out_cnt", longint'(m_out_cnt), exp_m[0].cnt);
                    check("main out_ovf", longint'(m_out_ovf), exp_m[0].ovf);
                    if (out_rdy) begin
                        r = exp_m.pop_front();
                        r.acc = longint'($signed(m_out_acc));
                        r.cnt = longint'(m_out_cnt);
                        r.ovf = longint'(m_out_ovf);
                        r.src_cyc = r.cyc;
                        r.cyc = cyc;
                        got_m.push_back(r);
                    end
                end
            end
            if (s_out_vld) begin
                check("sat16 result pending", longint'(exp_s.size() > 0), 1);
                if (exp_s.size() > 0) begin
                    check("sat16 out_acc", longint'($signed(s_out_acc)), exp_s[0].acc);
                    check("sat16 out_cnt", longint'(s_out_cnt), exp_s[0].cnt);
                    check("sat16 out_ovf", longint'(s_out_ovf), exp_s[0].ovf);
                    if (out_rdy) begin
                        r = exp_s.pop_front();
                        r.acc = longint'($signed(s_out_acc));
                        r.ovf = longint'(s_out_ovf);
                        got_s.push_back(r);
                    end
                end
            end
            if (w_out_vld) begin
                check("wrap16 result pending", longint'(exp_w.size() > 0), 1);
                if (exp_w.size() > 0) begin
                    check("wrap16 out_acc", longint'($signed(w_out_acc)), exp_w[0].acc);
                    check("wrap16 out_cnt", longint'(w_out_cnt), exp_w[0].cnt);
                    check("wrap16 out_ovf", longint'(w_out_ovf), exp_w[0].ovf);
                    if (out_rdy) begin
                        r = exp_w.pop_front();
                        r.acc = longint'($signed(w_out_acc));
                        r.ovf = longint'(w_out_ovf);
                        got_w.push_back(r);
                    end
                end
            end

            // A flush throws away every beat not yet folded into a result.
            if (!clr_n) begin
                cur.delete();
            end else if (in_vld && m_in_rdy) begin
                cur.push_back(longint'($signed(a)) * longint'($signed(b)));
                if (in_last) begin
                    r = model_vec(cur, 26, 0); r.cyc = cyc; exp_m.push_back(r);
                    r = model_vec(cur, 16, 1); r.cyc = cyc; exp_s.push_back(r);
                    r = model_vec(cur, 16, 0); r.cyc = cyc; exp_w.push_back(r);
                    cur.delete();
                end
            end
        end
    end

    // Present one beat (called just after a rising edge) and hold it until accepted.
    task automatic beat(input int av, input int bv, input bit last);
        int n = 0;
        bit hs = 0;
        a = av[7:0];
        b = bv[7:0];
        in_last = last;
        in_vld = 1'b1;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = m_in_rdy;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) check("beat accepted", longint'(hs), 1);
        in_vld = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int t = 0;
        while (got_m.size() < n && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("results arrived", got_m.size(), n);
    endtask

    task automatic pulse_clr();
        clr_n = 1'b0;
        @(posedge clk);
        #1;
        clr_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
        $fatal(1);
    end

    initial begin
        longint prods[$];
        res_t   r;
        int     base;
        bit     done;

        // Model pins: hand-computed vectors.
        prods = '{15, -24, 16129, 16384};
        r = model_vec(prods, 26, 0);
        check("model dot acc", r.acc, 32504);
        prods = '{16129, 16129, 16129, 16129};
        r = model_vec(prods, 16, 1);
        check("model sat acc", r.acc, 32767);
        check("model sat ovf", r.ovf, 1);
        r = model_vec(prods, 16, 0);
        check("model wrap acc", r.acc, -1020);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset out_vld", longint'(m_out_vld), 0);
        check("reset out_acc", longint'(m_out_acc), 0);
        check("reset out_cnt", longint'(m_out_cnt), 0);
        check("reset out_ovf", longint'(m_out_ovf), 0);
        check("reset in_rdy", longint'(m_in_rdy), 1);
        @(posedge clk);
        #1;

        // Reset mid-vector leaves no residue.
        base = got_m.size();
        beat(50, 50, 0);
        beat(50, 50, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        beat(2, 3, 1);
        wait_results(base + 1);
        check("reset vec acc", got_m[base].acc, 6);
        check("reset vec cnt", got_m[base].cnt, 1);
        check("reset vec ovf", got_m[base].ovf, 0);

        // Dot product with default widths, plus latency.
        base = got_m.size();
        beat(3, 5, 0);
        beat(-4, 6, 0);
        beat(127, 127, 0);
        beat(-128, -128, 1);
        wait_results(base + 1);
        check("dot acc", got_m[base].acc, 32504);
        check("dot cnt", got_m[base].cnt, 4);
        check("dot ovf", got_m[base].ovf, 0);
        check("dot latency", got_m[base].cyc - got_m[base].src_cyc, 2);

        // Overflow in the 16-bit instances.
        base = got_m.size();
        for (int i = 0; i < 4; i++) beat(127, 127, i == 3);
        wait_results(base + 1);
        check("ovf main acc", got_m[base].acc, 64516);
        check("ovf main ovf", got_m[base].ovf, 0);
        check("ovf sat acc", got_s[base].acc, 32767);
        check("ovf sat ovf", got_s[base].ovf, 1);
        check("ovf wrap acc", got_w[base].acc, -1020);
        check("ovf wrap ovf", got_w[base].ovf, 1);

        // Backpressure with back-to-back vectors.
        base = got_m.size();
        saw_bp_block = 0;
        fork
            begin
                beat(1, 1, 0); beat(1, 1, 1);
                beat(2, 2, 0); beat(2, 2, 1);
            end
            begin
                out_rdy = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_rdy = 1'b1;
            end
        join
        wait_results(base + 2);
        check("bp in_rdy dropped", longint'(saw_bp_block), 1);
        check("bp first acc", got_m[base].acc, 2);
        check("bp first cnt", got_m[base].cnt, 2);
        check("bp second acc", got_m[base + 1].acc, 8);
        check("bp second cnt", got_m[base + 1].cnt, 2);

        // Clear while a result is pending, then clear a partial vector.
        base = got_m.size();
        out_rdy = 1'b0;
        beat(7, 7, 1);
        beat(10, 10, 0);
        pulse_clr();
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) beat(10, 10, 0);
        pulse_clr();
        beat(4, 4, 1);
        wait_results(base + 2);
        check("clr pending acc", got_m[base].acc, 49);
        check("clr new acc", got_m[base + 1].acc, 16);
        check("clr new cnt", got_m[base + 1].cnt, 1);

        // New result loading in the same cycle the old one leaves.
        base = got_m.size();
        beat(3, 3, 1);
        beat(5, 5, 1);
        wait_results(base + 2);
        check("b2b first acc", got_m[base].acc, 9);
        check("b2b second acc", got_m[base + 1].acc, 25);
        check("b2b no bubble", got_m[base + 1].cyc - got_m[base].cyc, 1);

        // Randomized vectors with random gaps and backpressure.
        done = 0;
        fork
            begin
                for (int v = 0; v < 250; v++) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int j = 0; j < len; j++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                        beat(int'($urandom), int'($urandom), j == len - 1);
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    out_rdy = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_rdy = 1'b1;
            end
        join

        // Drain: nothing may be left undelivered.
        for (int t = 0; t < 50 && exp_m.size() > 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("drain main", exp_m.size(), 0);
        check("drain sat16", exp_s.size(), 0);
        check("drain wrap16", exp_w.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
